// File: rtl/aes256_key_expand_if.sv
// Request/result bus for the AES-256 key expander: start/key in, busy/done
// status out, and a random-access read port onto the round-key store.
interface aes256_key_expand_if;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    modport master (
        output start,
        output key,
        output rk_addr,
        input  busy,
        input  done,
        input  rk_data
    );

    modport slave (
        input  start,
        input  key,
        input  rk_addr,
        output busy,
        output done,
        output rk_data
    );
endinterface

// File: rtl/aes256_key_expand.sv
// AES-256 key expansion: one schedule word per cycle through an 8-word
// sliding window, writing the 15 round keys into a readable register store.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; round-key store holds the last result
// EXPAND | producing w[i] for i = 8..59, one word per cycle
// FIN    | one-cycle done pulse, all round keys valid; start ignored

// 32-bit byte-wise S-box. Each byte is the GF(2^8) inverse followed by the
// AES affine transform, computed arithmetically rather than by lookup table.
module aes_sbox_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) prod = prod ^ acc;
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // x^254 equals x^-1 for x != 0 and maps 0 to 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] res;
        pw  = gf_mul(x, x);
        res = pw;
        for (int k = 2; k < 8; k++) begin
            pw  = gf_mul(pw, pw);
            res = gf_mul(res, pw);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = gf_inv(x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Substitute every byte independently.
    always_comb begin
        dout = '0;
        for (int b = 0; b < 4; b++) begin
            dout[8*b +: 8] = sbox(din[8*b +: 8]);
        end
    end

endmodule

module aes256_key_expand (
    input  logic                clk,
    input  logic                rst_n,
    aes256_key_expand_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_FIN    = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic [31:0]  win_q [0:7];
    logic [31:0]  win_d [0:7];
    logic [127:0] rk_q  [0:14];
    logic [127:0] rk_d  [0:14];

    logic [31:0]  prev_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp_word;
    logic [31:0]  new_word;
    logic [7:0]   rcon;

    // win_q[7] is w[i-1], win_q[0] is w[i-8]; the S-box input is rotated
    // only on the i%8==0 words, so one S-box serves both substitution cases.
    always_comb begin
        prev_word = win_q[7];
        sub_in    = (i_q[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        rcon      = 8'h01 << (i_q[5:3] - 3'd1);
        temp_word = prev_word;
        if (i_q[2:0] == 3'd0) begin
            temp_word = sub_out ^ {rcon, 24'h000000};
        end else if (i_q[2:0] == 3'd4) begin
            temp_word = sub_out;
        end
        new_word = win_q[0] ^ temp_word;
    end

    aes_sbox_word u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    // Next-state, counter, window shift and round-key writes.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        win_d   = win_q;
        rk_d    = rk_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    for (int k = 0; k < 8; k++) begin
                        win_d[k] = bus.key[255 - 32*k -: 32];
                    end
                    rk_d[0] = bus.key[255:128];
                    rk_d[1] = bus.key[127:0];
                    i_d     = 6'd8;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                for (int k = 0; k < 7; k++) begin
                    win_d[k] = win_q[k+1];
                end
                win_d[7] = new_word;
                // A round key completes on every fourth word; its index is i/4.
                if (i_q[1:0] == 2'd3) begin
                    for (int j = 2; j < 15; j++) begin
                        if (i_q[5:2] == 4'(j)) begin
                            rk_d[j] = {win_q[5], win_q[6], win_q[7], new_word};
                        end
                    end
                end
                if (i_q == 6'd59) begin
                    state_d = ST_FIN;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, window and round-key registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= 6'd8;
            for (int k = 0; k < 8; k++) begin
                win_q[k] <= '0;
            end
            for (int j = 0; j < 15; j++) begin
                rk_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            for (int k = 0; k < 8; k++) begin
                win_q[k] <= win_d[k];
            end
            for (int j = 0; j < 15; j++) begin
                rk_q[j] <= rk_d[j];
            end
        end
    end

    assign bus.busy = (state_q == ST_EXPAND);
    assign bus.done = (state_q == ST_FIN);

    // Unregistered read port; address 15 has no key behind it and reads zero.
    always_comb begin
        bus.rk_data = '0;
        for (int j = 0; j < 15; j++) begin
            if (bus.rk_addr == 4'(j)) begin
                bus.rk_data = rk_q[j];
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand: FIPS-197 and all-zero keys, ignored
// re-starts, reset mid-expansion and back-to-back runs, checked against a
// table-driven key-schedule model and hand-taken round-key constants.
module tb_aes256_key_expand;

    localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_ALT  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_B    = 256'h0123456789abcdeffedcba987654321000112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes256_key_expand_if bus();

    aes256_key_expand u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] rk_ref [0:14];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [2047:0] tbl;
        tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
               128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
               128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
               128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
               128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
               128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
               128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
               128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        return tbl[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subword_ref(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_ref(input int n);
        case (n)
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h04;
            4: return 8'h08;
            5: return 8'h10;
            6: return 8'h20;
            7: return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_expand(input logic [255:0] k);
        logic [31:0] w [0:59];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)      t = subword_ref({t[23:0], t[31:24]}) ^ {rcon_ref(i/8), 24'h0};
            else if (i % 8 == 4) t = subword_ref(t);
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++) rk_ref[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic sweep(input string pfx, input bit zeros);
        logic [127:0] exp;
        for (int a = 0; a < 16; a++) begin
            bus.rk_addr = 4'(a);
            #1;
            exp = (zeros || a == 15) ? 128'h0 : rk_ref[a];
            check_val($sformatf("%s_rk%0d", pfx, a), bus.rk_data, exp);
        end
    endtask

    task automatic read_rk(input int a, output logic [127:0] d);
        bus.rk_addr = 4'(a);
        #1;
        d = bus.rk_data;
    endtask

    // Start one expansion and follow it to done; optional re-pulses of start
    // with another key during EXPAND must be ignored.
    task automatic run_expand(input logic [255:0] k, input bit glitch, output int lat, output bit busy_gap);
        @(negedge clk);
        bus.key   = k;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.key   = ~k;
        lat       = -1;
        busy_gap  = !bus.busy;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (!bus.busy) busy_gap = 1'b1;
            if (glitch && (c == 5 || c == 30)) begin
                bus.start = 1'b1;
                bus.key   = KEY_ALT;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_run_end(input string pfx, input int lat, input bit busy_gap);
        check_val({pfx, "_latency"}, 128'(lat), 128'd52);
        check_val({pfx, "_busy_gap"}, 128'(busy_gap), 128'd0);
        check_val({pfx, "_done_busy_fin"}, 128'({bus.done, bus.busy}), 128'b10);
        @(posedge clk);
        #1;
        check_val({pfx, "_done_busy_idle"}, 128'({bus.done, bus.busy}), 128'b00);
    endtask

    initial begin
        int lat;
        bit gap;
        bit seen;
        logic [127:0] d;

        bus.start   = 1'b0;
        bus.key     = '0;
        bus.rk_addr = 4'd0;

        // Reset state
        #12;
        check_val("reset_done_busy", 128'({bus.done, bus.busy}), 128'b00);
        sweep("reset", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 key
        run_expand(KEY_FIPS, 1'b0, lat, gap);
        check_run_end("fips", lat, gap);
        read_rk(1, d);  check_val("fips_rk1_const",  d, 128'h101112131415161718191a1b1c1d1e1f);
        read_rk(2, d);  check_val("fips_rk2_const",  d, 128'ha573c29fa176c498a97fce93a572c09c);
        read_rk(14, d); check_val("fips_rk14_const", d, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        model_expand(KEY_FIPS);
        sweep("fips", 1'b0);

        // All-zero key
        run_expand(256'h0, 1'b0, lat, gap);
        check_run_end("zero", lat, gap);
        read_rk(0, d); check_val("zero_rk0_const", d, 128'h0);
        read_rk(1, d); check_val("zero_rk1_const", d, 128'h0);
        read_rk(2, d); check_val("zero_rk2_const", d, 128'h62636363626363636263636362636363);
        model_expand(256'h0);
        sweep("zero", 1'b0);

        // Start re-pulsed with another key during EXPAND
        run_expand(KEY_FIPS, 1'b1, lat, gap);
        check_run_end("glitch", lat, gap);
        model_expand(KEY_FIPS);
        sweep("glitch", 1'b0);

        // Reset asserted mid-expansion
        @(negedge clk);
        bus.key   = KEY_FIPS;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_done_busy", 128'({bus.done, bus.busy}), 128'b00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check_val("abort_no_activity", 128'(seen), 128'd0);
        sweep("abort", 1'b1);

        // Back-to-back with start held high: key A then key B
        @(negedge clk);
        bus.key   = KEY_FIPS;
        bus.start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check_val("b2b_first_latency", 128'(lat), 128'd53);
        bus.key = KEY_B;
        seen = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            #1;
            if (bus.busy) seen = 1'b1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        check_val("b2b_second_busy", 128'(seen), 128'd1);
        check_val("b2b_second_done", 128'(lat > 0), 128'd1);
        @(posedge clk);
        #1;
        model_expand(KEY_B);
        sweep("b2b", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
